// File: rtl/lcd_mmio_ctrl.sv
// lcd_mmio_ctrl: buffered HD44780-style LCD controller, MMIO write FIFO plus self-timed E strobe.
// Optional LCD_SIM_PRINT_EN echoes each character strobe to the simulator console.
module lcd_mmio_ctrl #(
    parameter int FIFO_DEPTH      = 8,
    parameter int SETUP_CYCLES    = 2,
    parameter int PULSE_CYCLES    = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int LONG_CMD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wen,
    output logic [31:0] bus_rdata,
    output logic [7:0]  lcd_data,
    output logic [1:0]  lcd_ctrl,
    output logic        lcd_enable,
    output logic        busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int HL   = HOLD_CYCLES + LONG_CMD_CYCLES;
    localparam int SP   = SETUP_CYCLES > PULSE_CYCLES ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAXC = SP > HL ? SP : HL;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [NW-1:0] cnt_q;
    logic          ovf_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          full, empty, wr_fifo, push, pop, long_cmd;

    assign full     = cnt_q == NW'(FIFO_DEPTH);
    assign empty    = cnt_q == '0;
    assign wr_fifo  = bus_sel & bus_wen & ~bus_addr[1];
    assign push     = wr_fifo & ~full;
    assign pop      = (state_q == IDLE) & ~empty;
    assign long_cmd = ~rs_q & (data_q inside {8'h01, 8'h02, 8'h03});

    // Storage carries no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk)
        if (push) mem_q[wp_q] <= {~bus_addr[0], bus_wdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            tmr_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            wp_q    <= push ? wp_q + AW'(1) : wp_q;
            rp_q    <= pop ? rp_q + AW'(1) : rp_q;
            cnt_q   <= cnt_q + NW'(push) - NW'(pop);
            ovf_q   <= (wr_fifo & full) ? 1'b1
                     : (bus_sel & bus_wen & (bus_addr == 2'd2) & bus_wdata[3]) ? 1'b0 : ovf_q;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        data_d  = data_q;
        rs_d    = rs_q;
        case (state_q)
            IDLE:
                if (!empty) begin
                    {rs_d, data_d} = mem_q[rp_q];
                    state_d        = SETUP;
                    tmr_d          = TW'(SETUP_CYCLES - 1);
                end
            SETUP: begin
                state_d = tmr_q == '0 ? PULSE : SETUP;
                tmr_d   = tmr_q == '0 ? TW'(PULSE_CYCLES - 1) : tmr_q - TW'(1);
            end
            PULSE: begin
                state_d = tmr_q == '0 ? HOLD : PULSE;
                tmr_d   = tmr_q != '0 ? tmr_q - TW'(1)
                        : long_cmd ? TW'(HL - 1) : TW'(HOLD_CYCLES - 1);
            end
            default: begin
                state_d = tmr_q == '0 ? IDLE : HOLD;
                tmr_d   = tmr_q == '0 ? tmr_q : tmr_q - TW'(1);
            end
        endcase
    end

    assign lcd_data   = data_q;
    assign lcd_ctrl   = {rs_q, 1'b0};
    assign lcd_enable = state_q == PULSE;
    assign busy       = ~empty | (state_q != IDLE);
    assign bus_rdata  = (bus_sel && bus_addr == 2'd2)
                      ? {16'h0, 8'(cnt_q), 4'h0, ovf_q, empty, full, busy} : 32'h0;

`ifdef LCD_SIM_PRINT_EN
    always @(negedge lcd_enable)
        if (lcd_ctrl == 2'b10) $write("%c", lcd_data);
`endif
endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// tb_lcd_mmio_ctrl: scoreboard bench; expected strobes come from an edge-accurate timeline model.
module tb_lcd_mmio_ctrl;
    localparam int DEPTH = 8, S = 2, PU = 4, H = 2, L = 64;

    logic        clk = 0, rst_n = 0, bus_sel = 0, bus_wen = 0;
    logic [1:0]  bus_addr = 0;
    logic [7:0]  bus_wdata = 0;
    logic [31:0] bus_rdata;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_ctrl;
    logic        lcd_enable, busy;
    int          cyc = 0, checks = 0, errors = 0;

    lcd_mmio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_rdata(bus_rdata),
        .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl), .lcd_enable(lcd_enable), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each accepted byte gets its pop, rise, fall and idle edges computed once at accept time.
    typedef struct {int acc; int pop; int idle;} ent_t;
    typedef struct {logic [7:0] d; logic rs; int rise; int fall;} exp_t;
    typedef struct {int e; bit v;} ovf_t;
    ent_t ents[$];
    exp_t sb[$];
    ovf_t oev[$];
    int   free_e = 0;

    function automatic int m_count(int t);
        int n = 0;
        foreach (ents[i]) if (ents[i].acc <= t && ents[i].pop > t) n++;
        return n;
    endfunction

    function automatic bit m_busy(int t);
        foreach (ents[i]) if (ents[i].acc <= t && ents[i].idle > t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_status(int t);
        logic [31:0] s = '0;
        int n = m_count(t);
        s[15:8] = 8'(n);
        foreach (oev[i]) if (oev[i].e <= t) s[3] = oev[i].v;
        s[2] = n == 0;
        s[1] = n == DEPTH;
        s[0] = m_busy(t);
        return s;
    endfunction

    function automatic void model_write(int e, logic [1:0] a, logic [7:0] d);
        int p, rise, fall, idl;
        bit lng;
        if (a < 2) begin
            if (m_count(e - 1) == DEPTH) oev.push_back('{e, 1'b1});
            else begin
                p     = (e + 1 > free_e) ? e + 1 : free_e;
                rise  = p + S;
                fall  = rise + PU;
                lng   = a == 1 && d >= 8'h01 && d <= 8'h03;
                idl   = fall + H + (lng ? L : 0);
                free_e = idl + 1;
                ents.push_back('{e, p, idl});
                sb.push_back('{d, a == 0, rise, fall});
            end
        end else if (a == 2 && d[3]) oev.push_back('{e, 1'b0});
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at edge %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(logic s, logic w, logic [1:0] a, logic [7:0] d);
        @(negedge clk);
        bus_sel = s; bus_wen = w; bus_addr = a; bus_wdata = d;
        if (s && w) model_write(cyc + 1, a, d);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'd2, 8'h00);
    endtask

    task automatic wait_drain();
        bit done = 0;
        idle();
        for (int i = 0; i < 3000 && !done; i++) begin
            idle();
            #1;
            done = !busy;
        end
        if (!done) chk("drain_timeout", 32'(busy), 32'h0);
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_enable", 32'(lcd_enable), 32'h0);
        chk("rst_data", 32'(lcd_data), 32'h0);
        chk("rst_ctrl", 32'(lcd_ctrl), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_status", bus_rdata, 32'h4);
    endtask

    // Monitor: compares status/busy every cycle and pops the scoreboard on each E strobe.
    initial begin
        logic prev = 0;
        bit   have = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev = 0;
                have = 0;
            end else begin
                chk(bus_sel && bus_addr == 2 ? "status" : "rdata_zero", bus_rdata,
                    bus_sel && bus_addr == 2 ? m_status(cyc) : 32'h0);
                chk("busy", 32'(busy), 32'(m_busy(cyc)));
                if (lcd_enable && !prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse data %h at edge %0d, none queued", lcd_data, cyc);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1;
                        chk("rise_edge", cyc, cur.rise);
                        chk("lcd_data", 32'(lcd_data), 32'(cur.d));
                        chk("lcd_ctrl", 32'(lcd_ctrl), {30'h0, cur.rs, 1'b0});
                    end
                end
                if (!lcd_enable && prev && have) begin
                    chk("fall_edge", cyc, cur.fall);
                    chk("fall_data", 32'(lcd_data), 32'(cur.d));
                    have = 0;
                end
                prev = lcd_enable;
            end
        end
    end

    initial begin
        int   r;
        bit   found;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        bus_sel = 1; bus_addr = 2;
        reset_checks();
        @(negedge clk);
        rst_n = 1;

        drive(1, 1, 0, 8'h48);
        wait_drain();
        drive(1, 1, 0, 8'h48); drive(1, 1, 0, 8'h69); drive(1, 1, 0, 8'h21);
        wait_drain();
        drive(1, 1, 1, 8'h01); drive(1, 1, 0, 8'h41);
        wait_drain();
        drive(1, 1, 1, 8'h01);
        for (int i = 0; i < 9; i++) drive(1, 1, 0, 8'h30 + 8'(i));
        idle(); idle();
        drive(1, 1, 2, 8'h08);
        drive(1, 1, 3, 8'h55);
        drive(1, 0, 3, 8'h00);
        wait_drain();

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 7);
            d = 8'($urandom);
            if (r <= 1) drive(1, 1, 0, d);
            else if (r == 2) drive(1, 1, 1, $urandom_range(0, 15) == 0 ? 8'($urandom_range(1, 3)) : d);
            else if (r == 3) drive(1, 1, 2, d);
            else if (r == 4) drive(1, $urandom_range(0, 1) == 1, 3, d);
            else if (r == 5) drive(0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), d);
            else idle();
        end
        wait_drain();

        for (int i = 0; i < 5; i++) drive(1, 1, 0, 8'h61 + 8'(i));
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle();
            #1;
            found = lcd_enable;
        end
        if (!found) chk("pulse_timeout", 32'(lcd_enable), 32'h1);
        @(negedge clk);
        rst_n = 0;
        bus_sel = 1; bus_wen = 0; bus_addr = 2;
        @(negedge clk);
        ents.delete(); sb.delete(); oev.delete(); free_e = 0;
        reset_checks();
        @(negedge clk);
        rst_n = 1;
        repeat (40) idle();
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_mmio_ctrl.md
# lcd_mmio_ctrl

Memory-mapped HD44780-style LCD controller that replaces hand-driven LCD data/ctrl/enable registers with a buffered, self-timing peripheral. The CPU pushes character and command bytes into a parametrised FIFO through a simple decoded write port. A sequencer drains the FIFO and generates setup/enable/hold timing itself, with extra wait time for slow LCD commands. It sits beside the RAM on the CPU bus; the top-level decodes the I/O region into `bus_sel`.

## Interface
- `FIFO_DEPTH`, 8: entry count; power of two, ≥2
- `SETUP_CYCLES`, 2: cycles data/ctrl are stable before enable rises; ≥1
- `PULSE_CYCLES`, 4: enable-high cycles; ≥1
- `HOLD_CYCLES`, 2: enable-low cycles after the falling edge; ≥1
- `LONG_CMD_CYCLES`, 64: extra hold cycles after commands 0x01/0x02/0x03; ≥0
- `clk` in 1: system clock
- `rst_n` in 1: synchronous, active-low reset
- `bus_sel` in 1: I/O region selected (decoded by the top-level)
- `bus_addr` in 2: register offset
- `bus_wdata` in 8: write data (byte lane 0)
- `bus_wen` in 1: write strobe (byte lane 0 enable)
- `bus_rdata` out 32: combinational read data
- `lcd_data` out 8: LCD data bus
- `lcd_ctrl` out 2: {RS, RW}; RW is always 0
- `lcd_enable` out 1: LCD E strobe
- `busy` out 1: high when the FIFO is non-empty or the sequencer is not IDLE

## Operation
- Registers:
  - offset 0 DATA (write): push {RS=1, byte}.
  - offset 1 CMD (write): push {RS=0, byte}.
  - offset 2 STATUS (read): bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[15:8] count.
  - Writing offset 2 with bit3=1 clears overflow.
  - offset 3 is reserved: reads 0, writes are ignored.
- `bus_rdata` returns STATUS when `bus_sel` and `bus_addr==2`; otherwise 0.
- Push is accepted when `bus_sel & bus_wen` and offset is 0 or 1 and the FIFO is not full. A push attempted while full is dropped and sets sticky overflow.
- Sequencer states:
  - IDLE: if the FIFO is non-empty, pop the head, load `lcd_data`/`lcd_ctrl`, go to SETUP.
  - SETUP: lasts SETUP_CYCLES, then go to PULSE.
  - PULSE: `lcd_enable`=1 for PULSE_CYCLES, then go to HOLD.
  - HOLD: `lcd_enable`=0 for HOLD_CYCLES, plus LONG_CMD_CYCLES when RS=0 and byte ∈ {0x01,0x02,0x03}, then go to IDLE.
- `lcd_data`/`lcd_ctrl` hold their last value through IDLE.
- Arithmetic:
  - Count width is $clog2(FIFO_DEPTH)+1, so a full FIFO is distinguished from an empty one.
  - Pointers wrap modulo FIFO_DEPTH.
  - The cycle counter is wide enough for max(SETUP, PULSE, HOLD+LONG_CMD).
- Simultaneous push and pop (FIFO not full): both occur and count is unchanged. A push while full is dropped even if a pop happens in the same cycle.

## Timing
- Reset (`rst_n` low at a rising edge):
  - `lcd_data`=0, `lcd_ctrl`=0, `lcd_enable`=0.
  - FIFO emptied, overflow=0, state=IDLE, `busy`=0.
  - A reset mid-pulse drops enable at that edge and discards queued entries.
- Write at edge N: count increments at N.
- Pop: at edge N+1; `lcd_data` is valid after N+1.
- `lcd_enable` rises at edge N+1+SETUP_CYCLES and falls PULSE_CYCLES edges later.
- IDLE is re-entered HOLD_CYCLES (plus any long-command cycles) edges after the fall.
- Back-to-back entries:
  - Period is 1+SETUP+PULSE+HOLD cycles; 9 cycles with the defaults.
  - The pop is the single IDLE cycle.
- `busy` and STATUS reflect registered state, with no combinational path from the bus write.

## Configuration
- `LCD_SIM_PRINT_EN`:
  - Defined: a non-synthesisable block prints `lcd_data` with `$write("%c")` on every falling edge of `lcd_enable` where `lcd_ctrl==2'b10`.
  - Undefined: the print block is absent; synthesised hardware is identical either way.

## Test plan
- Write DATA 0x48 at edge 0 → `lcd_data`=0x48, `lcd_ctrl`=2'b10 after edge 1; `lcd_enable` high at edges 3–6 and low from edge 7; `busy` falls after edge 9.
- Write DATA 0x48, 0x69, 0x21 back-to-back → three enable pulses exactly 9 cycles apart; with the macro defined, the simulation prints "Hi!".
- Write CMD 0x01 then DATA 0x41 → `lcd_ctrl`=2'b00 during the first pulse; the second pop is delayed by 64 extra cycles (73-cycle period).
- 9 writes with the sequencer stalled by a long command → STATUS full=1, count=8, overflow=1 and the 9th byte is never output; write 0x08 to STATUS → overflow=0.
- Push while popping at count=3 → count stays 3; pointer wrap verified after 20 entries with output order preserved.
- Assert `rst_n`=0 mid-PULSE with 4 entries queued → after that edge `lcd_enable`=0, count=0, empty=1, `lcd_data`=0, and no further pulses.
